// File: rtl/puf_crp_collector_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : puf_pkg
//  Description : Shared types and constants for the arbiter-PUF CRP collector.
//                FSM state encoding, vote-counter sizing helper and the
//                default 64-bit challenge LFSR feedback mask.
//  Revision    : 1.0  initial release
// ============================================================================
package puf_pkg;

  // FSM state encoding, kept as plain constants for legacy tool flows
  typedef logic [2:0] state_t;

  localparam state_t c_IDLE   = 3'd0;
  localparam state_t c_SETTLE = 3'd1;
  localparam state_t c_FIRE   = 3'd2;
  localparam state_t c_SAMPLE = 3'd3;
  localparam state_t c_EMIT   = 3'd4;
  localparam state_t c_HOLD   = 3'd5;

  // Default Galois feedback mask for a 64-bit challenge
  localparam logic [63:0] c_DEFAULT_TAPS = 64'hD800_0000_0000_0000;

  // A vote counter must hold every value from 0 up to the repeat count
  function automatic int vote_width(input int repeats);
    return $clog2(repeats + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/puf_challenge_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : puf_challenge_lfsr
//  Description : Galois LFSR challenge generator. Loads a seed (an all-zero
//                seed is replaced by 1 so the register can never lock up)
//                and advances one step on request. Output is the raw state.
//  Revision    : 1.0  initial release
// ============================================================================
module puf_challenge_lfsr #(
  parameter int           W    = 64,
  parameter logic [W-1:0] TAPS = '1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_load,
  input  logic [W-1:0] i_seed,
  input  logic         i_step,
  output logic [W-1:0] o_state
);

  logic [W-1:0] r_state;
  logic [W-1:0] w_seed_fix;
  logic [W-1:0] w_next;

  // All-zero is the LFSR's dead state, so substitute 1
  assign w_seed_fix = (i_seed == '0) ? W'(1) : i_seed;

  // Right-shifting Galois step: feedback mask applied when bit 0 falls out
  assign w_next = (r_state >> 1) ^ (r_state[0] ? TAPS : '0);

  // State register: load has priority over step
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= '0;
    end else if (i_load) begin
      r_state <= w_seed_fix;
    end else if (i_step) begin
      r_state <= w_next;
    end
  end

  assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/puf_crp_collector.sv
`default_nettype none
// ============================================================================
//  Module      : puf_crp_collector
//  Description : Arbiter-PUF initiator. Generates LFSR challenges, fires the
//                launch edge REPEATS times per challenge, majority-votes the
//                synchronised responses and streams out CRPs with a
//                per-bit stability mask over a valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module puf_crp_collector
  import puf_pkg::*;
#(
  parameter int                CHAL_W     = 64,
  parameter int                RESP_W     = 8,
  parameter logic [CHAL_W-1:0] TAPS       = c_DEFAULT_TAPS[CHAL_W-1:0],
  parameter int                REPEATS    = 7,
  parameter int                SETTLE_CYC = 16,
  parameter int                EVAL_CYC   = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [CHAL_W-1:0] seed,
  input  logic [15:0]       num_crp,
  output logic [CHAL_W-1:0] puf_challenge,
  output logic              puf_launch,
  input  logic [RESP_W-1:0] puf_response,
  output logic              crp_valid,
  input  logic              crp_ready,
  output logic [CHAL_W-1:0] crp_challenge,
  output logic [RESP_W-1:0] crp_response,
  output logic [RESP_W-1:0] crp_stable,
  output logic              busy,
  output logic              done
);

  localparam int VW      = vote_width(REPEATS);
  localparam int CNT_MAX = (SETTLE_CYC > EVAL_CYC) ? SETTLE_CYC : EVAL_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] c_SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] c_EVAL_LAST   = CNT_W'(EVAL_CYC - 1);
  localparam logic [VW-1:0]    c_REP_LAST    = VW'(REPEATS - 1);
  localparam logic [VW-1:0]    c_HALF        = VW'(REPEATS / 2);
  localparam logic [VW-1:0]    c_ALL         = VW'(REPEATS);

  state_t                        r_state;
  logic [CNT_W-1:0]              r_cnt;
  logic [VW-1:0]                 r_rep;
  logic [15:0]                   r_remaining;
  logic [RESP_W-1:0][VW-1:0]     r_vote;
  logic [RESP_W-1:0]             r_sync1;
  logic [RESP_W-1:0]             r_sync2;
  logic                          r_valid;
  logic [CHAL_W-1:0]             r_crp_chal;
  logic [RESP_W-1:0]             r_crp_resp;
  logic [RESP_W-1:0]             r_crp_stable;
  logic                          r_done;

  logic                          w_load;
  logic                          w_accept;
  logic                          w_next_crp;
  logic [CHAL_W-1:0]             w_lfsr_state;
  logic [RESP_W-1:0]             w_vote_resp;
  logic [RESP_W-1:0]             w_vote_stable;

  // A run starts only from IDLE with a non-empty CRP count
  assign w_load     = (r_state == c_IDLE) && start && (num_crp != 16'd0);
  assign w_accept   = (r_state == c_HOLD) && r_valid && crp_ready;
  // Advancing the LFSR here is what keeps the challenge frozen during launches
  assign w_next_crp = w_accept && (r_remaining != 16'd1);

  puf_challenge_lfsr #(
    .W    (CHAL_W),
    .TAPS (TAPS)
  ) u_lfsr (
    .clk     (clk),
    .rstn    (rstn),
    .i_load  (w_load),
    .i_seed  (seed),
    .i_step  (w_next_crp),
    .o_state (w_lfsr_state)
  );

  // Two-flop synchroniser for the asynchronous arbiter outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= puf_response;
      r_sync2 <= r_sync1;
    end
  end

  // Per-bit vote counters: cleared per challenge, accumulated in SAMPLE
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vote <= '0;
    end else if (w_load || w_next_crp) begin
      r_vote <= '0;
    end else if (r_state == c_SAMPLE) begin
      for (int i = 0; i < RESP_W; i++) begin
        r_vote[i] <= r_vote[i] + VW'(r_sync2[i]);
      end
    end
  end

  // Majority decision and unanimity mask from the finished vote counts
  always_comb begin
    w_vote_resp   = '0;
    w_vote_stable = '0;
    for (int i = 0; i < RESP_W; i++) begin
      w_vote_resp[i]   = (r_vote[i] > c_HALF);
      w_vote_stable[i] = (r_vote[i] == '0) || (r_vote[i] == c_ALL);
    end
  end

  // Main sequencer: settle / fire / sample per repeat, then emit and hold
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= c_IDLE;
      r_cnt        <= '0;
      r_rep        <= '0;
      r_remaining  <= '0;
      r_valid      <= 1'b0;
      r_crp_chal   <= '0;
      r_crp_resp   <= '0;
      r_crp_stable <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (start) begin
            if (num_crp != 16'd0) begin
              r_remaining <= num_crp;
              r_rep       <= '0;
              r_cnt       <= '0;
              r_state     <= c_SETTLE;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        c_SETTLE: begin
          if (r_cnt == c_SETTLE_LAST) begin
            r_cnt   <= '0;
            r_state <= c_FIRE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        c_FIRE: begin
          if (r_cnt == c_EVAL_LAST) begin
            r_cnt   <= '0;
            r_state <= c_SAMPLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        c_SAMPLE: begin
          if (r_rep == c_REP_LAST) begin
            r_state <= c_EMIT;
          end else begin
            r_rep   <= r_rep + VW'(1);
            r_state <= c_SETTLE;
          end
        end
        c_EMIT: begin
          r_crp_chal   <= w_lfsr_state;
          r_crp_resp   <= w_vote_resp;
          r_crp_stable <= w_vote_stable;
          r_valid      <= 1'b1;
          r_state      <= c_HOLD;
        end
        c_HOLD: begin
          if (w_accept) begin
            r_valid     <= 1'b0;
            r_remaining <= r_remaining - 16'd1;
            if (r_remaining == 16'd1) begin
              r_done  <= 1'b1;
              r_state <= c_IDLE;
            end else begin
              r_rep   <= '0;
              r_cnt   <= '0;
              r_state <= c_SETTLE;
            end
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign puf_challenge = w_lfsr_state;
  assign puf_launch    = (r_state == c_FIRE) || (r_state == c_SAMPLE);
  assign crp_valid     = r_valid;
  assign crp_challenge = r_crp_chal;
  assign crp_response  = r_crp_resp;
  assign crp_stable    = r_crp_stable;
  assign busy          = (r_state != c_IDLE);
  assign done          = r_done;

endmodule
`default_nettype wire
